// File: rtl/minimig_autoconfig_chain.sv
// Zorro autoconfig daisy chain: presents each enabled slot's config ROM in turn
// and records the base address (or shut-up) that software writes back.
module minimig_autoconfig_chain #(
  parameter int          NUM_BOARDS   = 4,
  parameter logic [15:0] MANUFACTURER = 16'h07DB,
  parameter logic [7:0]  PRODUCT_BASE = 8'h01
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk7_en,
  input  logic [7:0]              address_in,
  input  logic [15:0]             data_in,
  input  logic                    rd,
  input  logic                    hwr,
  input  logic                    lwr,
  input  logic                    sel,
  input  logic [NUM_BOARDS-1:0]   board_enable,
  input  logic [NUM_BOARDS-1:0]   board_zorro3,
  input  logic [4*NUM_BOARDS-1:0] board_size,
  output logic [15:0]             data_out,
  output logic [NUM_BOARDS-1:0]   board_configured,
  output logic [NUM_BOARDS-1:0]   board_shutup,
  output logic [8*NUM_BOARDS-1:0] board_base,
  output logic                    autoconfig_done
);

  localparam int IW = $clog2(NUM_BOARDS + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_BOARDS);

  typedef enum logic [1:0] {INIT, SCAN, PRESENT, DONE} state_t;

  state_t            state, state_next;
  logic [IW-1:0]     index, index_next;
  logic [NUM_BOARDS-1:0] enabled;
  logic              cur_enabled;
  logic              cur_zorro3;
  logic [3:0]        cur_size;
  logic [7:0]        product;
  logic [3:0]        nibble;
  logic [7:0]        config_offset;
  logic              bus_write;
  logic              config_write;
  logic              shutup_write;
  logic              unused_inputs;

  // Reads are answered combinationally; the low data byte and rd carry no meaning here.
  assign unused_inputs = ^{rd, data_in[7:0]};

  always_comb begin
    cur_enabled = 1'b0;
    cur_zorro3  = 1'b0;
    cur_size    = 4'h0;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (index == IW'(i)) begin
        cur_enabled = enabled[i];
        cur_zorro3  = board_zorro3[i];
        cur_size    = board_size[4*i +: 4];
      end
    end
  end

  assign product       = PRODUCT_BASE + 8'(index);
  assign config_offset = cur_zorro3 ? 8'h22 : 8'h24;
  assign bus_write     = clk7_en & sel & (hwr | lwr);

  // address_in is a word address, so byte offset N appears here as N/2.
  always_comb begin
    nibble = 4'hF;
    case (address_in)
      8'h00:   nibble = cur_zorro3 ? 4'h8 : 4'hC;
      8'h01:   nibble = cur_size;
      8'h02:   nibble = ~product[7:4];
      8'h03:   nibble = ~product[3:0];
      8'h08:   nibble = ~MANUFACTURER[15:12];
      8'h09:   nibble = ~MANUFACTURER[11:8];
      8'h0A:   nibble = ~MANUFACTURER[7:4];
      8'h0B:   nibble = ~MANUFACTURER[3:0];
      default: nibble = 4'hF;
    endcase
  end

  assign data_out        = (state == PRESENT && sel) ? {nibble, 12'hFFF} : 16'h0000;
  assign autoconfig_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  always_comb begin
    state_next   = state;
    index_next   = index;
    config_write = 1'b0;
    shutup_write = 1'b0;
    case (state)
      INIT: begin
        index_next = '0;
        state_next = SCAN;
      end
      SCAN: begin
        if (index == LAST)
          state_next = DONE;
        else if (cur_enabled)
          state_next = PRESENT;
        else
          index_next = index + 1'b1;
      end
      PRESENT: begin
        if (bus_write && address_in == config_offset)
          config_write = 1'b1;
        else if (bus_write && address_in == 8'h26)
          shutup_write = 1'b1;
        if (config_write || shutup_write) begin
          index_next = index + 1'b1;
          state_next = SCAN;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = INIT;
    endcase
  end

  // Presence flags are frozen at INIT so hot changes cannot disturb a running chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      enabled          <= '0;
      board_configured <= '0;
      board_shutup     <= '0;
      board_base       <= '0;
    end else begin
      if (state == INIT)
        enabled <= board_enable;
      for (int i = 0; i < NUM_BOARDS; i++) begin
        if (index == IW'(i)) begin
          if (config_write) begin
            board_base[8*i +: 8] <= data_in[15:8];
            board_configured[i]  <= 1'b1;
          end
          if (shutup_write)
            board_shutup[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_minimig_autoconfig_chain.sv
// Bench for minimig_autoconfig_chain: directed scenarios plus randomized
// chains checked against a slot-list model of the autoconfig protocol.
module tb_minimig_autoconfig_chain;

  localparam int          NB  = 4;
  localparam logic [15:0] MAN = 16'h07DB;
  localparam logic [7:0]  PB  = 8'h01;
  localparam int          SETTLE = NB + 2;

  logic            clk;
  logic            reset;
  logic            clk7_en;
  logic [7:0]      address_in;
  logic [15:0]     data_in;
  logic            rd, hwr, lwr, sel;
  logic [NB-1:0]   board_enable, board_zorro3;
  logic [4*NB-1:0] board_size;
  logic [15:0]     data_out;
  logic [NB-1:0]   board_configured, board_shutup;
  logic [8*NB-1:0] board_base;
  logic            autoconfig_done;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [NB-1:0] m_enable, m_zorro3, m_configured, m_shutup;
  logic [3:0]    m_size [NB];
  logic [7:0]    m_base [NB];
  int            m_ptr;

  minimig_autoconfig_chain #(.NUM_BOARDS(NB), .MANUFACTURER(MAN), .PRODUCT_BASE(PB)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .address_in(address_in),
    .data_in(data_in), .rd(rd), .hwr(hwr), .lwr(lwr), .sel(sel),
    .board_enable(board_enable), .board_zorro3(board_zorro3), .board_size(board_size),
    .data_out(data_out), .board_configured(board_configured), .board_shutup(board_shutup),
    .board_base(board_base), .autoconfig_done(autoconfig_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expectEqual(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The slot being offered is the first enabled slot at or after the pointer.
  function automatic int curSlot();
    for (int i = m_ptr; i < NB; i++)
      if (m_enable[i]) return i;
    return NB;
  endfunction

  function automatic logic [3:0] modelNibble(input int slot, input logic [8:0] off);
    logic [7:0]  prod;
    logic [15:0] man;
    prod = PB + 8'(slot);
    man  = MAN;
    case (off)
      9'h000:  return m_zorro3[slot] ? 4'h8 : 4'hC;
      9'h002:  return m_size[slot];
      9'h004:  return ~prod[7:4];
      9'h006:  return ~prod[3:0];
      9'h010:  return ~man[15:12];
      9'h012:  return ~man[11:8];
      9'h014:  return ~man[7:4];
      9'h016:  return ~man[3:0];
      default: return 4'hF;
    endcase
  endfunction

  function automatic void modelWrite(input logic [7:0] addr, input logic [15:0] data,
                                     input logic s, input logic en, input logic h, input logic l);
    int slot;
    logic [8:0] off;
    slot = curSlot();
    off  = {addr, 1'b0};
    if (slot < NB && s && en && (h || l)) begin
      if (off == (m_zorro3[slot] ? 9'h044 : 9'h048)) begin
        m_base[slot] = data[15:8];
        m_configured[slot] = 1'b1;
        m_ptr = slot + 1;
      end else if (off == 9'h04C) begin
        m_shutup[slot] = 1'b1;
        m_ptr = slot + 1;
      end
    end
  endfunction

  task automatic idle(input int n);
    sel = 1'b0; rd = 1'b0; hwr = 1'b0; lwr = 1'b0; clk7_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setBoards(input logic [NB-1:0] en, input logic [NB-1:0] z3, input logic [4*NB-1:0] sz);
    board_enable = en;
    board_zorro3 = z3;
    board_size   = sz;
    m_zorro3     = z3;
    for (int i = 0; i < NB; i++) m_size[i] = sz[4*i +: 4];
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_enable = board_enable;
    m_ptr = 0;
    m_configured = '0;
    m_shutup = '0;
    for (int i = 0; i < NB; i++) m_base[i] = 8'h00;
  endtask

  task automatic checkReset(input string tag);
    address_in = 8'h00; sel = 1'b1; rd = 1'b1;
    #1;
    expectEqual({tag, "_data"}, 32'(data_out), 32'h0);
    expectEqual({tag, "_cfg"}, 32'(board_configured), 32'h0);
    expectEqual({tag, "_shut"}, 32'(board_shutup), 32'h0);
    expectEqual({tag, "_base"}, board_base, 32'h0);
    expectEqual({tag, "_done"}, 32'(autoconfig_done), 32'h0);
    sel = 1'b0; rd = 1'b0;
    #1;
  endtask

  // One write bus cycle, then enough idle clocks for the chain to reach the next slot.
  task automatic applyStimulus(input logic [7:0] addr, input logic [15:0] data,
                               input logic s, input logic en, input logic h, input logic l);
    address_in = addr; data_in = data; sel = s; clk7_en = en; hwr = h; lwr = l;
    modelWrite(addr, data, s, en, h, l);
    @(posedge clk);
    #1;
    idle(SETTLE);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] addr);
    int slot;
    logic [15:0] exp_data;
    logic [8*NB-1:0] exp_base;
    slot = curSlot();
    exp_data = (slot < NB) ? {modelNibble(slot, {addr, 1'b0}), 12'hFFF} : 16'h0000;
    for (int i = 0; i < NB; i++) exp_base[8*i +: 8] = m_base[i];
    address_in = addr; sel = 1'b0; rd = 1'b1;
    #1;
    expectEqual({tag, "_nosel"}, 32'(data_out), 32'h0);
    sel = 1'b1;
    #1;
    expectEqual({tag, "_data"}, 32'(data_out), 32'(exp_data));
    expectEqual({tag, "_cfg"}, 32'(board_configured), 32'(m_configured));
    expectEqual({tag, "_shut"}, 32'(board_shutup), 32'(m_shutup));
    expectEqual({tag, "_base"}, board_base, exp_base);
    expectEqual({tag, "_done"}, 32'(autoconfig_done), 32'(slot == NB));
    sel = 1'b0; rd = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] bytes [4];
    int op, slot;
    logic [7:0] addr;
    logic hw, lw;

    reset = 1'b1; clk7_en = 1'b1; address_in = 8'h00; data_in = 16'h0000;
    rd = 1'b0; hwr = 1'b0; lwr = 1'b0; sel = 1'b0;
    setBoards('1, '0, 16'h1076);

    // Four ZII boards with sizes 6,7,0,1 configured in order.
    doReset();
    checkReset("rst");
    idle(SETTLE);
    bytes = '{8'h20, 8'h40, 8'h60, 8'h80};
    for (int k = 0; k < 4; k++) begin
      checkOutput("size_rd", 8'h01);
      applyStimulus(8'h24, {bytes[k], 8'h00}, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    expectEqual("full_base", board_base, 32'h80604020);
    expectEqual("full_cfg", 32'(board_configured), 32'hF);
    expectEqual("full_done", 32'(autoconfig_done), 32'h1);
    checkOutput("full_end", 8'h01);

    // No boards present: chain completes within NUM_BOARDS+2 clocks.
    setBoards('0, '0, 16'h0);
    doReset();
    repeat (NB + 2) @(posedge clk);
    #1;
    expectEqual("empty_done", 32'(autoconfig_done), 32'h1);
    checkOutput("empty_rd", 8'h00);

    // ZIII slot 0 ignores the ZII config offset and accepts 0x44.
    setBoards('1, 4'b0001, 16'h2222);
    doReset();
    idle(SETTLE);
    checkOutput("z3_type", 8'h00);
    applyStimulus(8'h24, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("z3_wrong", 8'h00);
    applyStimulus(8'h22, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b0);
    expectEqual("z3_base", 32'(board_base[7:0]), 32'h40);
    expectEqual("z3_cfg", 32'(board_configured[0]), 32'h1);

    // Shut-up on slot 0, then slot 1 is offered with product 0x02.
    setBoards('1, '0, 16'h3333);
    doReset();
    idle(SETTLE);
    applyStimulus(8'h26, 16'hFF00, 1'b1, 1'b1, 1'b0, 1'b1);
    expectEqual("shut_flags", 32'(board_shutup), 32'h1);
    expectEqual("shut_cfg0", 32'(board_configured[0]), 32'h0);
    address_in = 8'h03; sel = 1'b1;
    #1;
    expectEqual("shut_next_prod", 32'(data_out), 32'hDFFF);
    sel = 1'b0;
    checkOutput("shut_state", 8'h02);

    // Sparse chain: slot 1 skipped.
    setBoards(4'b0101, '0, 16'h4444);
    doReset();
    idle(SETTLE);
    applyStimulus(8'h24, 16'h1100, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h24, 16'h2200, 1'b1, 1'b1, 1'b1, 1'b0);
    expectEqual("sparse_done", 32'(autoconfig_done), 32'h1);
    expectEqual("sparse_cfg", 32'(board_configured), 32'h5);

    // Reset mid-chain restarts from slot 0 with everything cleared.
    setBoards('1, '0, 16'h5555);
    doReset();
    idle(SETTLE);
    applyStimulus(8'h24, 16'hA000, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h24, 16'hB000, 1'b1, 1'b1, 1'b1, 1'b0);
    doReset();
    checkReset("midrst");
    idle(SETTLE);
    address_in = 8'h08; sel = 1'b1;
    #1;
    expectEqual("midrst_manuf", 32'(data_out), 32'hFFFF);
    sel = 1'b0;
    checkOutput("midrst_slot0", 8'h03);

    // Randomized chains against the slot-list model.
    for (int t = 0; t < 16; t++) begin
      setBoards(NB'($urandom), NB'($urandom), (4*NB)'($urandom));
      doReset();
      idle(SETTLE);
      board_enable = NB'($urandom);
      checkOutput("rnd_start", 8'(($urandom_range(0, 15))));
      for (int n = 0; n < 12; n++) begin
        op   = $urandom_range(0, 6);
        slot = curSlot();
        hw   = 1'($urandom);
        lw   = ~hw | 1'($urandom);
        case (op)
          0: addr = 8'(($urandom_range(0, 15)));
          1: addr = (slot < NB && m_zorro3[slot]) ? 8'h22 : 8'h24;
          2: addr = (slot < NB && m_zorro3[slot]) ? 8'h24 : 8'h22;
          3: addr = 8'h26;
          default: addr = (slot < NB && m_zorro3[slot]) ? 8'h22 : 8'h24;
        endcase
        if (op == 6) addr = 8'($urandom);
        if (op != 0)
          applyStimulus(addr, 16'($urandom), op != 4, op != 5, hw, lw);
        checkOutput("rnd", 8'(($urandom_range(0, 15))));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
